delta_spike_event_queue: RTL

Downstream stage of the delta-modulation spike encoder. Each enabled sample cycle it takes the encoder's 2-bit spike output, stamps every non-zero spike with a free-running sample timestamp, and buffers the events in a small FIFO. Events are drained through a valid/ready port toward the host or serializer. It also keeps sticky error and overflow status and a dropped-event count, so lost events are visible.

---
 rtl/delta_pkg.sv | 17 +
 rtl/delta_evt_fifo.sv | 70 +++++++
 rtl/delta_spike_event_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation spike event path.
//   POL_ON / POL_OFF : polarity codes stored with each event ({ON, OFF} bits)
//   SPK_ON / SPK_OFF : bit positions of the ON/OFF spike in the encoder output
//   evt_width()      : width of one event word, {polarity[1:0], timestamp}
package delta_pkg;

  localparam logic [1:0] POL_ON  = 2'b10;
  localparam logic [1:0] POL_OFF = 2'b01;

  localparam int SPK_ON  = 1;
  localparam int SPK_OFF = 0;

  function automatic int evt_width(input int ts_width);
    return ts_width + 2;
  endfunction

endpackage

// File: rtl/delta_evt_fifo.sv
// Synchronous FIFO for timestamped spike events.
//   clk, reset : clock, synchronous active-high reset
//   flush      : synchronous empty of the FIFO (storage contents kept)
//   push, din  : write request and data; ignored while full unless popping
//   pop        : read request; ignored while empty
//   dout       : registered storage entry at the read pointer
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
module delta_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             wr_en;
  logic             rd_en;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      // NOTE: storage is reset only because the head must read as zero
      // out of reset; the flush path leaves it alone to keep that port cheap.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/delta_spike_event_queue.sv
// Timestamps delta-modulation spikes and queues them for a valid/ready consumer.
//   clk, reset        : clock, synchronous active-high reset (priority over clear)
//   sample_en         : one encoder sample per high cycle; advances the timestamp
//   spike_in          : encoder output, bit1 = ON, bit0 = OFF; 11 is invalid
//   clear             : synchronous soft clear of FIFO, status and timestamp
//   evt_valid/ready   : event handshake, pop when both are high
//   evt_data          : {polarity[1:0], timestamp}, zero while no event is held
//   level             : FIFO occupancy
//   overflow          : sticky, an event was dropped on a full FIFO
//   spike_err         : sticky, spike_in was 11 on a sample
//   drop_cnt          : dropped events, saturating at 15
module delta_spike_event_queue
  import delta_pkg::*;
#(
  parameter int TS_WIDTH = 6,
  parameter int DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_en,
  input  logic [1:0]                     spike_in,
  input  logic                           clear,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [evt_width(TS_WIDTH)-1:0] evt_data,
  output logic [$clog2(DEPTH):0]         level,
  output logic                           overflow,
  output logic                           spike_err,
  output logic [3:0]                     drop_cnt
);

  localparam int EW = evt_width(TS_WIDTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic                spike_err_q, spike_err_d;
  logic [3:0]          drop_cnt_q, drop_cnt_d;

  logic          push_req;
  logic          invalid;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] fifo_dout;

  // Exactly one of the two spike bits set is a valid event.
  assign push_req = sample_en && (spike_in[SPK_ON] ^ spike_in[SPK_OFF]);
  assign invalid  = sample_en && spike_in[SPK_ON] && spike_in[SPK_OFF];
  assign pop      = evt_valid && evt_ready;
  assign drop     = push_req && fifo_full && !pop;

  delta_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (clear),
    .push  (push_req && !clear),
    .pop   (pop),
    .din   ({spike_in, ts_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign evt_valid = !fifo_empty;
  // Stale storage is hidden so the port only ever shows a live event or zero.
  assign evt_data  = evt_valid ? fifo_dout : '0;
  assign overflow  = overflow_q;
  assign spike_err = spike_err_q;
  assign drop_cnt  = drop_cnt_q;

  // NOTE: every variable driven here is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    ts_d        = ts_q;
    overflow_d  = overflow_q;
    spike_err_d = spike_err_q;
    drop_cnt_d  = drop_cnt_q;
    if (sample_en) begin
      ts_d = ts_q + 1'b1;
    end
    if (invalid) begin
      spike_err_d = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 4'hF) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
    if (clear) begin
      ts_d        = '0;
      overflow_d  = 1'b0;
      spike_err_d = 1'b0;
      drop_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q        <= '0;
      overflow_q  <= 1'b0;
      spike_err_q <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      ts_q        <= ts_d;
      overflow_q  <= overflow_d;
      spike_err_q <= spike_err_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule
